// File: rtl/combat_resolver.sv
`default_nettype none
// ============================================================================
//  Module   : combat_resolver
//  Purpose  : Hitbox/hurtbox overlap, damage, blocking, guard regen, hitstun
//             and round-end resolution for a two-player fighter.
//  Revision : 1.0
// ============================================================================
module combat_resolver #(
    parameter int CHAR_WIDTH      = 128,
    parameter int HURT_X1         = 44,
    parameter int HURT_X2         = 84,
    parameter int HIT_X1          = 5,
    parameter int HIT_X2          = 43,
    parameter int MAX_HEALTH      = 3,
    parameter int DMG1            = 1,
    parameter int DMG2            = 2,
    parameter int GUARD_MAX       = 3,
    parameter int HITSTUN_CYC     = 20,
    parameter int GUARD_REGEN_CYC = 120
) (
    input  logic       clk_game,
    input  logic       reset,
    input  logic [3:0] state_p1,
    input  logic [3:0] state_p2,
    input  logic [9:0] char1_x,
    input  logic [9:0] char2_x,
    input  logic       new_round,
    output logic [3:0] health_p1,
    output logic [3:0] health_p2,
    output logic [1:0] guard_p1,
    output logic [1:0] guard_p2,
    output logic       hitstun_p1,
    output logic       hitstun_p2,
    output logic       hit_pulse_p1,
    output logic       hit_pulse_p2,
    output logic       block_pulse_p1,
    output logic       block_pulse_p2,
    output logic       round_over,
    output logic [1:0] winner
);

    localparam int c_stun_w  = $clog2(HITSTUN_CYC + 1);
    localparam int c_regen_w = $clog2(GUARD_REGEN_CYC + 1);

    localparam logic [10:0] c_char_w  = 11'(CHAR_WIDTH);
    localparam logic [10:0] c_hurt_x1 = 11'(HURT_X1);
    localparam logic [10:0] c_hurt_x2 = 11'(HURT_X2);
    localparam logic [10:0] c_hit_x1  = 11'(HIT_X1);
    localparam logic [10:0] c_hit_x2  = 11'(HIT_X2);

    localparam logic [3:0] c_max_health = 4'(MAX_HEALTH);
    localparam logic [3:0] c_dmg1       = 4'(DMG1);
    localparam logic [3:0] c_dmg2       = 4'(DMG2);
    localparam logic [1:0] c_guard_max  = 2'(GUARD_MAX);

    localparam logic [c_stun_w-1:0]  c_stun_load  = c_stun_w'(HITSTUN_CYC);
    localparam logic [c_regen_w-1:0] c_regen_last = c_regen_w'(GUARD_REGEN_CYC - 1);

    localparam logic [3:0] c_st_atk1_active = 4'd4;
    localparam logic [3:0] c_st_atk2_active = 4'd7;

    logic [3:0]  w_state     [2];
    logic [10:0] w_hit_lo    [2];
    logic [10:0] w_hit_hi    [2];
    logic [10:0] w_hurt_lo   [2];
    logic [10:0] w_hurt_hi   [2];
    logic        w_connect   [2];
    logic [3:0]  w_dmg       [2];
    logic [3:0]  w_health_nx [2];
    logic [3:0]  w_health    [2];
    logic [1:0]  w_guard     [2];
    logic        w_stun      [2];
    logic        w_hit_pulse [2];
    logic        w_blk_pulse [2];

    logic [10:0] w_x1;
    logic [10:0] w_x2;
    logic        r_round_over;
    logic [1:0]  r_winner;

    assign w_state[0] = state_p1;
    assign w_state[1] = state_p2;
    assign w_x1       = {1'b0, char1_x};
    assign w_x2       = {1'b0, char2_x};

    // P1 faces +x, P2 faces -x: boxes are mirrored about the sprite.
    assign w_hit_lo[0]  = w_x1 + c_char_w - c_hit_x2;
    assign w_hit_hi[0]  = w_x1 + c_char_w - c_hit_x1;
    assign w_hurt_lo[0] = w_x1 + c_hurt_x1;
    assign w_hurt_hi[0] = w_x1 + c_hurt_x2;
    assign w_hit_lo[1]  = w_x2 + c_hit_x1;
    assign w_hit_hi[1]  = w_x2 + c_hit_x2;
    assign w_hurt_lo[1] = w_x2 + c_char_w - c_hurt_x2;
    assign w_hurt_hi[1] = w_x2 + c_char_w - c_hurt_x1;

    for (genvar p = 0; p < 2; p++) begin : g_player
        localparam int         c_opp  = 1 - p;
        localparam logic [3:0] c_away = (p == 0) ? 4'd1 : 4'd2;

        logic [3:0]           r_health;
        logic [1:0]           r_guard;
        logic [c_stun_w-1:0]  r_stun;
        logic [c_regen_w-1:0] r_regen;
        logic                 r_hit_done;
        logic                 r_hit_pulse;
        logic                 r_block_pulse;

        logic w_live;
        logic w_block;
        logic w_hit;

        assign w_live = (w_state[p] == c_st_atk1_active) ||
                        (w_state[p] == c_st_atk2_active);
        assign w_dmg[p] = (w_state[p] == c_st_atk2_active) ? c_dmg2 : c_dmg1;

        // This player as attacker against the opponent's hurtbox.
        assign w_connect[p] = w_live && !r_hit_done && !r_round_over &&
                              (w_hit_lo[p] < w_hurt_hi[c_opp]) &&
                              (w_hurt_lo[c_opp] < w_hit_hi[p]);

        // This player as defender.
        assign w_block = w_connect[c_opp] && (w_state[p] == c_away) &&
                         (r_stun == '0) && (r_guard != 2'd0);
        assign w_hit   = w_connect[c_opp] && !w_block;

        assign w_health_nx[p] = !w_hit                    ? r_health :
                                (r_health > w_dmg[c_opp]) ? (r_health - w_dmg[c_opp]) :
                                                            4'd0;

        always_ff @(posedge clk_game or negedge reset) begin
            if (!reset) begin
                r_health      <= c_max_health;
                r_guard       <= c_guard_max;
                r_stun        <= '0;
                r_regen       <= '0;
                r_hit_done    <= 1'b0;
                r_hit_pulse   <= 1'b0;
                r_block_pulse <= 1'b0;
            end else if (new_round) begin
                r_health      <= c_max_health;
                r_guard       <= c_guard_max;
                r_stun        <= '0;
                r_regen       <= '0;
                // A carried-over active frame must not land in the new round.
                r_hit_done    <= w_live;
                r_hit_pulse   <= 1'b0;
                r_block_pulse <= 1'b0;
            end else begin
                r_hit_pulse   <= w_hit;
                r_block_pulse <= w_block;

                if (w_hit) begin
                    r_stun <= c_stun_load;
                end else if (r_stun != '0) begin
                    r_stun <= r_stun - 1'b1;
                end

                if (!r_round_over) begin
                    r_health <= w_health_nx[p];

                    if (!w_live) begin
                        r_hit_done <= 1'b0;
                    end else if (w_connect[p]) begin
                        r_hit_done <= 1'b1;
                    end

                    if (w_block) begin
                        r_guard <= r_guard - 1'b1;
                        r_regen <= '0;
                    end else if (r_guard == c_guard_max) begin
                        r_regen <= '0;
                    end else if (r_regen == c_regen_last) begin
                        r_guard <= r_guard + 1'b1;
                        r_regen <= '0;
                    end else begin
                        r_regen <= r_regen + 1'b1;
                    end
                end
            end
        end

        assign w_health[p]    = r_health;
        assign w_guard[p]     = r_guard;
        assign w_stun[p]      = (r_stun != '0);
        assign w_hit_pulse[p] = r_hit_pulse;
        assign w_blk_pulse[p] = r_block_pulse;
    end

    // winner bit 1 flags P1 knocked out, bit 0 flags P2 knocked out.
    always_ff @(posedge clk_game or negedge reset) begin
        if (!reset) begin
            r_round_over <= 1'b0;
            r_winner     <= 2'b00;
        end else if (new_round) begin
            r_round_over <= 1'b0;
            r_winner     <= 2'b00;
        end else if (!r_round_over &&
                     ((w_health_nx[0] == 4'd0) || (w_health_nx[1] == 4'd0))) begin
            r_round_over <= 1'b1;
            r_winner     <= {w_health_nx[0] == 4'd0, w_health_nx[1] == 4'd0};
        end
    end

    assign health_p1      = w_health[0];
    assign health_p2      = w_health[1];
    assign guard_p1       = w_guard[0];
    assign guard_p2       = w_guard[1];
    assign hitstun_p1     = w_stun[0];
    assign hitstun_p2     = w_stun[1];
    assign hit_pulse_p1   = w_hit_pulse[0];
    assign hit_pulse_p2   = w_hit_pulse[1];
    assign block_pulse_p1 = w_blk_pulse[0];
    assign block_pulse_p2 = w_blk_pulse[1];
    assign round_over     = r_round_over;
    assign winner         = r_winner;

endmodule
`default_nettype wire
